// File: rtl/mem_stage_ld.sv
// MEM pipeline stage: registers EX results, waits on in-order data-memory responses,
// aligns/extends load data, buffers on WB stall, drops responses of flushed loads.
module mem_stage_ld #(
  parameter  int DATA_W   = 32,
  parameter  int PC_W     = 32,
  parameter  int RA_W     = 5,
  parameter  int CANCEL_W = 2,
  localparam int ES_W     = 5 + RA_W + PC_W + DATA_W,
  localparam int WS_W     = 1 + RA_W + PC_W + DATA_W,
  localparam int FWD_W    = 3 + RA_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              es_to_ms_valid,
  input  logic [ES_W-1:0]   es_to_ms_bus,
  output logic              ms_allow_in,
  input  logic              ws_allow_in,
  output logic              ms_to_ws_valid,
  output logic [WS_W-1:0]   ms_to_ws_bus,
  input  logic              ms_flush,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [FWD_W-1:0]  ms_fwd_bus
);

  localparam int                  OFF_W   = $clog2(DATA_W/8);
  localparam bit                  HAS_D   = (DATA_W == 64);
  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [2:0]        ld_op;
    logic              rf_or_mem;
    logic              rf_we;
    logic [RA_W-1:0]   dest;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] alu_result;
  } es_pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_t;

  es_pkt_t              es_in, ms_r;
  state_t               state, state_nxt;
  logic                 ms_valid;
  logic                 buf_valid;
  logic [DATA_W-1:0]    buf_data;
  logic [CANCEL_W-1:0]  cancel_cnt;

  logic data_acc, ms_ready_go, es_is_load, load_enter, retire;
  logic cancel_inc, cancel_dec;
  logic fwd_valid, fwd_blocked;

  logic [DATA_W-1:0] ld_src, lane, ld_result, final_result;
  logic [OFF_W-1:0]  off_msk, sh;

  assign es_in = es_to_ms_bus;

  // A response only belongs to the resident load once all cancelled ones are drained.
  assign data_acc    = (state == S_WAIT) & data_ok & (cancel_cnt == '0);
  assign ms_ready_go = !ms_r.rf_or_mem | data_acc | (state == S_HELD);
  assign es_is_load  = es_to_ms_valid & es_in.rf_or_mem;

  assign ms_allow_in    = (!ms_valid | (ms_ready_go & ws_allow_in)) &
                          !(es_is_load & (cancel_cnt == CNT_MAX));
  assign ms_to_ws_valid = ms_valid & ms_ready_go & !ms_flush;
  assign retire         = ms_to_ws_valid & ws_allow_in;
  assign load_enter     = ms_allow_in & es_is_load & !ms_flush;

  // Stage register. The retire branch covers a retire while entry is held off by a full cancel counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms_valid <= 1'b0;
      ms_r     <= '0;
    end else begin
      if (ms_flush)         ms_valid <= 1'b0;
      else if (ms_allow_in) ms_valid <= es_to_ms_valid;
      else if (retire)      ms_valid <= 1'b0;
      if (ms_allow_in & es_to_ms_valid) ms_r <= es_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ms_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (load_enter) state_nxt = S_WAIT;
        S_WAIT: if (data_acc)
                  state_nxt = ws_allow_in ? (load_enter ? S_WAIT : S_IDLE) : S_HELD;
        S_HELD: if (ws_allow_in) state_nxt = load_enter ? S_WAIT : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (data_acc & !ws_allow_in & !ms_flush) begin
      buf_valid <= 1'b1;
      buf_data  <= data_rdata;
    end else if (ms_flush | ws_allow_in) begin
      buf_valid <= 1'b0;
    end
  end

  // A flush of a waiting load whose response is not arriving this cycle leaves one response to drop.
  assign cancel_inc = ms_flush & (state == S_WAIT) & !data_acc;
  assign cancel_dec = data_ok & (cancel_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cancel_cnt <= '0;
    else if (cancel_inc & !cancel_dec & (cancel_cnt != CNT_MAX))
      cancel_cnt <= cancel_cnt + 1'b1;
    else if (!cancel_inc & cancel_dec)
      cancel_cnt <= cancel_cnt - 1'b1;
  end

  // Offset bits below the access size are ignored rather than trapped.
  always_comb begin
    case (ms_r.ld_op)
      3'b001, 3'b101: off_msk = '1;
      3'b010, 3'b110: off_msk = ~OFF_W'(1);
      3'b011:         off_msk = HAS_D ? {OFF_W{1'b0}} : ~OFF_W'(3);
      default:        off_msk = ~OFF_W'(3);
    endcase
    ld_src = buf_valid ? buf_data : data_rdata;
    sh     = ms_r.alu_result[OFF_W-1:0] & off_msk;
    lane   = ld_src >> {sh, 3'b000};
    case (ms_r.ld_op)
      3'b001:  ld_result = DATA_W'($signed(lane[7:0]));
      3'b101:  ld_result = DATA_W'(lane[7:0]);
      3'b010:  ld_result = DATA_W'($signed(lane[15:0]));
      3'b110:  ld_result = DATA_W'(lane[15:0]);
      3'b011:  ld_result = HAS_D ? lane : DATA_W'($signed(lane[31:0]));
      default: ld_result = DATA_W'($signed(lane[31:0]));
    endcase
  end

  assign final_result = ms_r.rf_or_mem ? ld_result : ms_r.alu_result;
  assign ms_to_ws_bus = {ms_r.rf_we, ms_r.dest, ms_r.pc, final_result};

  assign fwd_valid   = ms_valid & ms_r.rf_we;
  assign fwd_blocked = ms_valid & ms_r.rf_or_mem & !ms_ready_go;
  assign ms_fwd_bus  = {fwd_valid, fwd_blocked, ms_r.rf_we, ms_r.dest, final_result};

endmodule
